eth_rx_mac_filter: RTL

Receive-path destination-MAC filter that sits directly downstream of the RX AXI-Stream CDC FIFO, in the controller clock domain. It consumes byte-wide Ethernet frames, buffers the 6-byte destination address, and decides per frame whether to forward it (unicast match, broadcast, promiscuous) or silently discard it. It emits per-frame length and accept/drop/runt status pulses.

---
 rtl/eth_rx_mac_filter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/eth_rx_mac_filter.sv
// Receive-side destination MAC filter: buffers the 6-byte destination address,
// decides forward/discard per frame, then replays the header and passes the payload.
module eth_rx_mac_filter #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  input  logic [47:0]          cfg_mac_addr,
  input  logic                 cfg_bcast_en,
  input  logic                 cfg_promisc,
  output logic [LEN_WIDTH-1:0] m_frame_len,
  output logic                 m_frame_len_valid,
  output logic                 status_frame_accept,
  output logic                 status_frame_drop,
  output logic                 status_frame_runt
);

  typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

  state_t               state, state_next;
  logic [7:0]           hdr_buf [6];
  logic [2:0]           idx, ridx;
  logic                 hdr_last, hdr_user;
  logic [LEN_WIDTH-1:0] len_cnt, len_inc;
  logic [47:0]          dst;
  logic                 match, in_hs;
  logic                 frame_done, frame_drop, frame_runt;

  // The 6th destination byte is still on the bus when the match decision is made
  assign dst   = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3], hdr_buf[4], s_axis_tdata};
  assign match = cfg_promisc | (dst == cfg_mac_addr) | (cfg_bcast_en & (dst == 48'hFFFF_FFFF_FFFF));
  assign in_hs = s_axis_tvalid & s_axis_tready;
  assign len_inc = (len_cnt == '1) ? len_cnt : len_cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'd0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    frame_done    = 1'b0;
    frame_drop    = 1'b0;
    frame_runt    = 1'b0;
    case (state)
      HDR: begin
        s_axis_tready = ~rst;
        if (s_axis_tvalid) begin
          if (idx == 3'd5) begin
            if (match)             state_next = REPLAY;
            else if (s_axis_tlast) frame_drop = 1'b1;
            else                   state_next = DROP;
          end else if (s_axis_tlast) begin
            frame_runt = 1'b1;
            frame_drop = 1'b1;
          end
        end
      end
      REPLAY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_buf[ridx];
        m_axis_tlast  = hdr_last & (ridx == 3'd5);
        m_axis_tuser  = hdr_user & (ridx == 3'd5);
        if (m_axis_tready && ridx == 3'd5) begin
          state_next = hdr_last ? HDR : PASS;
          frame_done = hdr_last;
        end
      end
      PASS: begin
        m_axis_tvalid = s_axis_tvalid & ~rst;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready & ~rst;
        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
          state_next = HDR;
          frame_done = 1'b1;
        end
      end
      DROP: begin
        s_axis_tready = ~rst;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = HDR;
          frame_drop = 1'b1;
        end
      end
      default: state_next = HDR;
    endcase
  end

  // Header capture, replay index, length counting and registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      idx                 <= 3'd0;
      ridx                <= 3'd0;
      hdr_last            <= 1'b0;
      hdr_user            <= 1'b0;
      len_cnt             <= '0;
      m_frame_len         <= '0;
      m_frame_len_valid   <= 1'b0;
      status_frame_accept <= 1'b0;
      status_frame_drop   <= 1'b0;
      status_frame_runt   <= 1'b0;
    end else begin
      m_frame_len_valid   <= frame_done;
      status_frame_accept <= frame_done;
      status_frame_drop   <= frame_drop;
      status_frame_runt   <= frame_runt;

      if (state == HDR && in_hs) begin
        hdr_buf[idx] <= s_axis_tdata;
        if (idx == 3'd5) begin
          hdr_last <= s_axis_tlast;
          hdr_user <= s_axis_tuser;
          idx      <= 3'd0;
        end else if (s_axis_tlast) begin
          idx <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
      end

      if (state == REPLAY && m_axis_tready)
        ridx <= (ridx == 3'd5) ? 3'd0 : ridx + 3'd1;

      // In REPLAY the last byte was already counted when it entered the header
      if (frame_done)
        m_frame_len <= (state == PASS) ? len_inc : len_cnt;

      if (frame_done || frame_drop) len_cnt <= '0;
      else if (in_hs)               len_cnt <= len_inc;
    end
  end

endmodule
